uart_txarb_m: RTL

Round-robin transmit scheduler that shares one `uart_m` transmitter among NREQ byte producers. It accepts a byte from one requester at a time, pulses `load` into the UART with the byte on `d`, and tracks `txbusy` until the frame has left `txpin`. Only then does it re-arbitrate. It sits between the application logic and `uart_m`, in the same clock domain.

---
 rtl/uart_txarb_pkg.sv | 24 ++
 rtl/uart_txarb_rr_pick.sv | 34 +++
 rtl/uart_txarb_m.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_txarb_pkg.sv
// Shared definitions for the uart_m transmit arbiter: FSM encoding, index width, clog2 helper.
// The optional send watchdog is enabled by defining UARTTXARB_TIMEOUT_EN.
package uart_txarb_pkg;

    // `define UARTTXARB_TIMEOUT_EN

    localparam int GW = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAITBUSY = 2'd1,
        WAITIDLE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_txarb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo NREQ.
// Zero latency; valid is low when no request is pending.
module rr_pick_m
    import uart_txarb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic            valid,
    output logic [GW-1:0]   idx
);

    logic [NREQ-1:0] rot;
    int              off;
    int              sum;

    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        valid = 1'b0;
        off   = 0;
        // Scan downward so the smallest offset from ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                off   = k;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        idx = GW'(sum);
    end

endmodule

// File: rtl/uart_txarb_m.sv
// Round-robin byte scheduler for one uart_m: load/ack/d/grant registered one cycle after req is sampled.
// No new grant until txbusy has risen and fallen; UARTTXARB_TIMEOUT_EN adds a watchdog on txbusy rising.
module uart_txarb_m
    import uart_txarb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TOCYCLES = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] reqd,
    output logic [NREQ-1:0]   ack,
    output logic              load,
    output logic [7:0]        d,
    input  logic              txbusy,
    output logic [GW-1:0]     grant,
    output logic              active,
    output logic              err
);

    state_t          state, state_nxt;
    logic [GW-1:0]   ptr, ptr_nxt, grant_nxt, win;
    logic [7:0]      d_nxt, win_byte;
    logic [NREQ-1:0] ack_nxt;
    logic            load_nxt, active_nxt, win_vld;

    if (NREQ < 2 || NREQ > 8 || TOCYCLES < 1) begin : g_param_chk
        $error("uart_txarb_m: NREQ must be 2..8 and TOCYCLES at least 1");
    end

    rr_pick_m #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (win_vld),
        .idx   (win)
    );

    always_comb begin
        win_byte = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (win == GW'(i)) win_byte = reqd[8*i +: 8];
        end
    end

`ifdef UARTTXARB_TIMEOUT_EN
    localparam int CNTW = clog2(TOCYCLES + 1);
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            err_nxt;
`endif

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        grant_nxt  = grant;
        d_nxt      = d;
        ack_nxt    = '0;
        load_nxt   = 1'b0;
        active_nxt = active;
`ifdef UARTTXARB_TIMEOUT_EN
        cnt_nxt    = cnt;
        err_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // A busy UART here is a foreign or pre-reset frame: let it drain first.
                if (win_vld && !txbusy) begin
                    state_nxt  = WAITBUSY;
                    d_nxt      = win_byte;
                    grant_nxt  = win;
                    load_nxt   = 1'b1;
                    active_nxt = 1'b1;
                    for (int i = 0; i < NREQ; i++) ack_nxt[i] = (win == GW'(i));
                    ptr_nxt    = (win == GW'(NREQ - 1)) ? '0 : win + 1'b1;
`ifdef UARTTXARB_TIMEOUT_EN
                    cnt_nxt    = '0;
`endif
                end
            end
            WAITBUSY: begin
                if (txbusy) begin
                    state_nxt = WAITIDLE;
                end
`ifdef UARTTXARB_TIMEOUT_EN
                else if (cnt == CNTW'(TOCYCLES - 1)) begin
                    err_nxt    = 1'b1;
                    active_nxt = 1'b0;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            WAITIDLE: begin
                if (!txbusy) begin
                    active_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            grant  <= '0;
            d      <= 8'h00;
            ack    <= '0;
            load   <= 1'b0;
            active <= 1'b0;
`ifdef UARTTXARB_TIMEOUT_EN
            cnt    <= '0;
            err    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            grant  <= grant_nxt;
            d      <= d_nxt;
            ack    <= ack_nxt;
            load   <= load_nxt;
            active <= active_nxt;
`ifdef UARTTXARB_TIMEOUT_EN
            cnt    <= cnt_nxt;
            err    <= err_nxt;
`endif
        end
    end

`ifndef UARTTXARB_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule
